id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Registered, parametrised decode stage for the pipelined core, placed between IF and EX.
//  Decodes inst[4:0] against the para.v opcode macros into ALU/CMP/mem/writeback controls
//  plus rd/rs/IMM fields. Uses a valid/ready handshake with a 1-entry skid buffer.
//  Supports flush. Optional load-use interlock.
// PARAMETERS
//  DATA_W  16  instruction/data width; IMM is zero-extended to DATA_W
//  REG_AW  3   register index width; rd=inst[5+REG_AW-1:5], rs=inst[5+2*REG_AW-1:5+REG_AW]
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       kill all held/in-flight instructions (taken branch)
//  in_valid   in   1       IF presents inst
//  in_ready   out  1       stage can accept inst this cycle
//  inst       in   DATA_W  instruction word
//  out_valid  out  1       decoded bundle valid to EX
//  out_ready  in   1       EX accepts bundle
//  rd, rs     out  REG_AW  register indices
//  IMM        out  DATA_W  long imm inst[DATA_W-1:5+REG_AW] if IMMSel, else inst[DATA_W-1:5+2*REG_AW]
//  ALUop      out  3 | CMPop out 2 | IMMop, RegWe, mem_ctrl, RWSel, ABSel, IMMSel out 1 each
//  stall_cnt  out  16      saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, all control outputs 0, rd/rs/IMM 0, stall_cnt 0.
//    in_ready=1 in the first cycle after reset.
//  - Decode table: ADD/SUB/AND/OR/XOR/SLL/SRL -> ALUop, RegWe.
//    ADDI/SUBI/SLLI/SRLI -> add IMMop. LI -> ADD_op, IMMop, RegWe, IMMSel.
//    SW -> ADD_op, IMMop, ABSel, mem_ctrl. LW -> ADD_op, IMMop, RegWe, RWSel, ABSel.
//    BEQ/BLE -> CMPop only. Unknown opcode -> all controls 0, out_valid still asserted (NOP).
//  - Latency: 1 cycle, in_valid&&in_ready at edge N -> bundle visible after edge N.
//  - Output register: loads when empty or out_ready=1. If out_valid&&!out_ready while
//    in_valid&&in_ready, the inst is captured into the skid entry.
//  - in_ready = !skid_full && !hazard. Skid drains into the output register on the first
//    out_ready. Output bundle holds stable while out_valid&&!out_ready.
//  - Ordering: skid content always precedes the new input; no reordering, drops or duplicates.
//  - Source reads: ALU reg-reg, BEQ, BLE, SW read rd and rs. ALU-imm reads rd.
//    LW reads rs. LI reads none.
//  - flush: next edge clears out_valid and skid, drops any same-cycle input.
//    Takes priority over all handshakes. stall_cnt is preserved.
//  - rst asserted mid-transfer: same as reset, in-flight bundles are lost.
//  - stall_cnt increments each cycle with in_valid&&hazard, saturating at 16'hFFFF.
// CONFIGURATION
//  ID_LOAD_USE_EN defined:
//    - hazard=1 when the output register holds a valid LW (RWSel=1) whose rd matches a
//      source the incoming inst reads.
//    - Incoming inst is held off until that LW leaves, exactly one bubble (out_valid=0)
//      follows the LW.
//  Undefined: hazard tied 0, stall_cnt stays 0, no bubbles; EX forwarding is responsible.
// TESTING
//  1. Reset, then stream ADDI rd=1 IMM=5 with out_ready=1:
//     -> next cycle out_valid=1, ALUop=ADD_op, IMMop=1, RegWe=1, IMM=16'd5.
//  2. LI rd=2 inst[15:8]=8'hA5 -> IMMSel=1, IMM=16'h00A5. Unknown opcode 5'h1F ->
//     out_valid=1, all controls 0.
//  3. Hold out_ready=0 for 3 cycles while feeding A,B,C:
//     -> A held, B in skid, in_ready=0, C held by IF. Release -> A,B,C in order, none lost.
//  4. Assert flush with out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1;
//     the inst offered during flush never appears.
//  5. ID_LOAD_USE_EN: LW rd=3 then ADD rd=4 rs=3 -> one bubble cycle, stall_cnt=1,
//     then ADD. With rs=5 -> no bubble.
//     Without the macro -> back-to-back, stall_cnt=0.
//  6. Random valid/ready/flush for 10k cycles against a reference queue model:
//     in-order delivery, no duplicates, outputs stable under stall.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: registered decode stage between IF and EX.
// The instruction opcode is inst[4:0]. The stage decodes it into ALU, compare,
// memory and writeback controls, and it also extracts the rd, rs and IMM fields.
// The input and output use a valid/ready handshake. A one-entry skid buffer
// lets the stage accept one instruction while EX is stalled.
// Optional feature: define ID_LOAD_USE_EN to add the load-use interlock. When
// it is enabled, an instruction that reads the destination of a held LW is
// stopped, and exactly one bubble follows that LW.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kills the output register, the skid entry and any same-cycle input
//   in_valid/in_ready     IF handshake; in_ready is combinational
//   inst                  instruction word
//   out_valid/out_ready   EX handshake
//   rd, rs, IMM           register indices and zero-extended immediate
//   ALUop, CMPop, IMMop, RegWe, mem_ctrl, RWSel, ABSel, IMMSel   decoded controls
//   stall_cnt             saturating count of hazard-stall cycles
module id_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs,
  output logic [DATA_W-1:0] IMM,
  output logic [2:0]        ALUop,
  output logic [1:0]        CMPop,
  output logic              IMMop,
  output logic              RegWe,
  output logic              mem_ctrl,
  output logic              RWSel,
  output logic              ABSel,
  output logic              IMMSel,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned RD_LSB   = 5;
  localparam int unsigned RS_LSB   = 5 + REG_AW;
  localparam int unsigned SIMM_LSB = 5 + 2 * REG_AW;

  // Opcode encodings (mirror of the core's opcode macros)
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_SUBI = 5'd8;
  localparam logic [4:0] OP_SLLI = 5'd9;
  localparam logic [4:0] OP_SRLI = 5'd10;
  localparam logic [4:0] OP_LI   = 5'd11;
  localparam logic [4:0] OP_SW   = 5'd12;
  localparam logic [4:0] OP_LW   = 5'd13;
  localparam logic [4:0] OP_BEQ  = 5'd14;
  localparam logic [4:0] OP_BLE  = 5'd15;

  // ALU codes start at 1, so that a NOP bundle is all zeros
  localparam logic [2:0] ADD_op = 3'd1;
  localparam logic [2:0] SUB_op = 3'd2;
  localparam logic [2:0] AND_op = 3'd3;
  localparam logic [2:0] OR_op  = 3'd4;
  localparam logic [2:0] XOR_op = 3'd5;
  localparam logic [2:0] SLL_op = 3'd6;
  localparam logic [2:0] SRL_op = 3'd7;
  localparam logic [1:0] BEQ_op = 2'd1;
  localparam logic [1:0] BLE_op = 2'd2;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] cmp_op;
    logic       imm_op;
    logic       reg_we;
    logic       mem_ctrl;
    logic       rw_sel;
    logic       ab_sel;
    logic       imm_sel;
  } ctrl_t;

  // Opcode to control bundle; unknown opcodes decode to an all-zero NOP
  function automatic ctrl_t decode(input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.alu_op = ADD_op; c.reg_we = 1'b1; end
      OP_SUB:  begin c.alu_op = SUB_op; c.reg_we = 1'b1; end
      OP_AND:  begin c.alu_op = AND_op; c.reg_we = 1'b1; end
      OP_OR:   begin c.alu_op = OR_op;  c.reg_we = 1'b1; end
      OP_XOR:  begin c.alu_op = XOR_op; c.reg_we = 1'b1; end
      OP_SLL:  begin c.alu_op = SLL_op; c.reg_we = 1'b1; end
      OP_SRL:  begin c.alu_op = SRL_op; c.reg_we = 1'b1; end
      OP_ADDI: begin c.alu_op = ADD_op; c.reg_we = 1'b1; c.imm_op = 1'b1; end
      OP_SUBI: begin c.alu_op = SUB_op; c.reg_we = 1'b1; c.imm_op = 1'b1; end
      OP_SLLI: begin c.alu_op = SLL_op; c.reg_we = 1'b1; c.imm_op = 1'b1; end
      OP_SRLI: begin c.alu_op = SRL_op; c.reg_we = 1'b1; c.imm_op = 1'b1; end
      OP_LI:   begin c.alu_op = ADD_op; c.reg_we = 1'b1; c.imm_op = 1'b1; c.imm_sel = 1'b1; end
      OP_SW:   begin c.alu_op = ADD_op; c.imm_op = 1'b1; c.ab_sel = 1'b1; c.mem_ctrl = 1'b1; end
      OP_LW:   begin
        c.alu_op = ADD_op; c.imm_op = 1'b1; c.reg_we = 1'b1; c.rw_sel = 1'b1; c.ab_sel = 1'b1;
      end
      OP_BEQ:  c.cmp_op = BEQ_op;
      OP_BLE:  c.cmp_op = BLE_op;
      default: c = '0;
    endcase
    return c;
  endfunction

  logic              out_valid_q, out_valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_inst_q, skid_inst_d;
  logic              hazard;

  logic              accept;
  logic              out_load;
  logic [DATA_W-1:0] load_inst;
  ctrl_t             load_ctrl;

  assign in_ready = !skid_valid_q && !hazard;
  assign accept   = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;
  // When the skid entry is full it is older than anything IF offers, so it is loaded first
  assign load_inst = skid_valid_q ? skid_inst_q : inst;
  assign load_ctrl = decode(load_inst[4:0]);

  // Next state for the output register and the skid entry; flush wins over everything
  always_comb begin
    out_valid_d  = out_valid_q;
    ctrl_d       = ctrl_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      skid_valid_d = 1'b0;
      if (skid_valid_q || accept) begin
        out_valid_d = 1'b1;
        ctrl_d      = load_ctrl;
        rd_d        = load_inst[RD_LSB +: REG_AW];
        rs_d        = load_inst[RS_LSB +: REG_AW];
        imm_d       = load_ctrl.imm_sel ? DATA_W'(load_inst[DATA_W-1:RS_LSB])
                                        : DATA_W'(load_inst[DATA_W-1:SIMM_LSB]);
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      ctrl_q       <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      imm_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      ctrl_q       <= ctrl_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      imm_q        <= imm_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

`ifdef ID_LOAD_USE_EN
  // Which sources the incoming instruction reads: {rd, rs}
  function automatic logic [1:0] src_reads(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
      OP_BEQ, OP_BLE, OP_SW:                 src_reads = 2'b11;
      OP_ADDI, OP_SUBI, OP_SLLI, OP_SRLI:    src_reads = 2'b10;
      OP_LW:                                 src_reads = 2'b01;
      default:                               src_reads = 2'b00;
    endcase
  endfunction

  logic [1:0]  reads;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign reads  = src_reads(inst[4:0]);
  // A held LW blocks a dependent instruction until the LW leaves; that gap is the bubble
  assign hazard = out_valid_q && ctrl_q.rw_sel &&
                  ((reads[1] && (inst[RD_LSB +: REG_AW] == rd_q)) ||
                   (reads[0] && (inst[RS_LSB +: REG_AW] == rd_q)));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign hazard    = 1'b0;
  assign stall_cnt = 16'd0;
`endif

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign rs        = rs_q;
  assign IMM       = imm_q;
  assign ALUop     = ctrl_q.alu_op;
  assign CMPop     = ctrl_q.cmp_op;
  assign IMMop     = ctrl_q.imm_op;
  assign RegWe     = ctrl_q.reg_we;
  assign mem_ctrl  = ctrl_q.mem_ctrl;
  assign RWSel     = ctrl_q.rw_sel;
  assign ABSel     = ctrl_q.ab_sel;
  assign IMMSel    = ctrl_q.imm_sel;

endmodule
